// File: rtl/fun_encode.sv
// Registered 8-to-3 priority encoder: collects request strobes into a pending set and issues one code per accepted transfer.
// Request to code takes 2 cycles; the code register is frozen while out_valid && !out_ready, and capture continues meanwhile.
module fun_encode #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pend_cnt,
  output logic       merged
);

  logic [7:0] pend;
  logic [7:0] pend_next;
  logic [7:0] clr_mask;
  logic [2:0] prio_idx;
  logic       load;

  // Later loop iterations overwrite earlier ones, so scan direction sets the winner.
  always_comb begin
    prio_idx = 3'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pend[i]) prio_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) prio_idx = 3'(i);
      end
    end
  end

  always_comb begin
    load      = (pend != 8'h00) && (!out_valid || out_ready);
    clr_mask  = load ? (8'h01 << prio_idx) : 8'h00;
    // OR-ing D after the clear lets a same-cycle re-strobe keep its bit pending.
    pend_next = (pend & ~clr_mask) | D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 8'h00;
      pend_cnt  <= 4'd0;
      merged    <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
      C         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= 4'($countones(pend_next));
      merged   <= |(D & pend & ~clr_mask);
      if (load) begin
        {A, B, C} <= prio_idx;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fun_encode.sv
// Directed bench for fun_encode: one high-priority and one low-priority instance driven from shared stimulus.
module tb_fun_encode;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       out_ready;

  logic       a_hi, b_hi, c_hi, valid_hi, merged_hi;
  logic [3:0] cnt_hi;
  logic       a_lo, b_lo, c_lo, valid_lo, merged_lo;
  logic [3:0] cnt_lo;

  logic [2:0] code_hi;
  logic [2:0] code_lo;
  assign code_hi = {a_hi, b_hi, c_hi};
  assign code_lo = {a_lo, b_lo, c_lo};

  int checks = 0;
  int errors = 0;

  fun_encode #(.PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst(rst), .D(D),
    .A(a_hi), .B(b_hi), .C(c_hi),
    .out_valid(valid_hi), .out_ready(out_ready),
    .pend_cnt(cnt_hi), .merged(merged_hi)
  );

  fun_encode #(.PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst(rst), .D(D),
    .A(a_lo), .B(b_lo), .C(c_lo),
    .out_valid(valid_lo), .out_ready(out_ready),
    .pend_cnt(cnt_lo), .merged(merged_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; D = 8'h00; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (cnt_hi !== 4'd0 || valid_hi !== 1'b0 || code_hi !== 3'd0 || merged_hi !== 1'b0) begin
      errors++;
      $display("FAIL reset_state cnt=%0d valid=%b code=%0d merged=%b expected 0/0/0/0", cnt_hi, valid_hi, code_hi, merged_hi);
    end
    rst = 1'b0;
    D = 8'hFF;
    tick();
    checks++;
    if (cnt_hi !== 4'd8) begin
      errors++;
      $display("FAIL full_pend_cnt got %0d expected 8", cnt_hi);
    end
    tick(); tick();
    checks++;
    if (cnt_hi !== 4'd8 || valid_hi !== 1'b1 || code_hi !== 3'd7) begin
      errors++;
      $display("FAIL full_stalled cnt=%0d valid=%b code=%0d expected 8/1/7", cnt_hi, valid_hi, code_hi);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_hi !== 4'd0 || valid_hi !== 1'b0 || code_hi !== 3'd0 || merged_hi !== 1'b0) begin
      errors++;
      $display("FAIL async_reset cnt=%0d valid=%b code=%0d merged=%b expected 0/0/0/0", cnt_hi, valid_hi, code_hi, merged_hi);
    end
    D = 8'h00;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (cnt_hi !== 4'd0 || valid_hi !== 1'b0 || code_hi !== 3'd0 || merged_hi !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d cnt=%0d valid=%b code=%0d merged=%b expected 0/0/0/0", n, cnt_hi, valid_hi, code_hi, merged_hi);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] exp_code;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_code = 3'(i);
      D = 8'h01 << i;
      tick();
      D = 8'h00;
      checks++;
      if (cnt_hi !== 4'd1 || valid_hi !== 1'b0) begin
        errors++;
        $display("FAIL single_capture idx %0d cnt=%0d valid=%b expected 1/0", i, cnt_hi, valid_hi);
      end
      tick();
      checks++;
      if (code_hi !== exp_code || valid_hi !== 1'b1 || cnt_hi !== 4'd0) begin
        errors++;
        $display("FAIL single_issue idx %0d code=%0d valid=%b cnt=%0d expected %0d/1/0", i, code_hi, valid_hi, cnt_hi, exp_code);
      end
      checks++;
      if (code_lo !== exp_code || valid_lo !== 1'b1) begin
        errors++;
        $display("FAIL single_issue_lo idx %0d code=%0d valid=%b expected %0d/1", i, code_lo, valid_lo, exp_code);
      end
      tick();
      checks++;
      if (valid_hi !== 1'b0 || code_hi !== exp_code) begin
        errors++;
        $display("FAIL single_drop idx %0d valid=%b code=%0d expected 0/%0d", i, valid_hi, code_hi, exp_code);
      end
    end
  endtask

  task automatic test_priority_drain();
    logic [2:0] exp_hi [4];
    logic [2:0] exp_lo [4];
    logic [3:0] exp_cnt [4];
    exp_hi[0] = 3'd7; exp_hi[1] = 3'd5; exp_hi[2] = 3'd2; exp_hi[3] = 3'd0;
    exp_lo[0] = 3'd0; exp_lo[1] = 3'd2; exp_lo[2] = 3'd5; exp_lo[3] = 3'd7;
    exp_cnt[0] = 4'd3; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd1; exp_cnt[3] = 4'd0;
    out_ready = 1'b1;
    D = 8'hA5;
    tick();
    D = 8'h00;
    checks++;
    if (cnt_hi !== 4'd4 || cnt_lo !== 4'd4) begin
      errors++;
      $display("FAIL drain_capture cnt_hi=%0d cnt_lo=%0d expected 4", cnt_hi, cnt_lo);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (code_hi !== exp_hi[n] || valid_hi !== 1'b1 || cnt_hi !== exp_cnt[n]) begin
        errors++;
        $display("FAIL drain_hi step %0d code=%0d valid=%b cnt=%0d expected %0d/1/%0d", n, code_hi, valid_hi, cnt_hi, exp_hi[n], exp_cnt[n]);
      end
      checks++;
      if (code_lo !== exp_lo[n] || valid_lo !== 1'b1 || cnt_lo !== exp_cnt[n]) begin
        errors++;
        $display("FAIL drain_lo step %0d code=%0d valid=%b cnt=%0d expected %0d/1/%0d", n, code_lo, valid_lo, cnt_lo, exp_lo[n], exp_cnt[n]);
      end
    end
    tick();
    checks++;
    if (valid_hi !== 1'b0 || valid_lo !== 1'b0) begin
      errors++;
      $display("FAIL drain_end valid_hi=%b valid_lo=%b expected 0/0", valid_hi, valid_lo);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    D = 8'h81;
    tick();
    D = 8'h00;
    checks++;
    if (cnt_hi !== 4'd2) begin
      errors++;
      $display("FAIL bp_capture cnt=%0d expected 2", cnt_hi);
    end
    tick();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (code_hi !== 3'd7 || valid_hi !== 1'b1 || cnt_hi !== 4'd1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d code=%0d valid=%b cnt=%0d expected 7/1/1", n, code_hi, valid_hi, cnt_hi);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (code_hi !== 3'd0 || valid_hi !== 1'b1 || cnt_hi !== 4'd0) begin
      errors++;
      $display("FAIL bp_release code=%0d valid=%b cnt=%0d expected 0/1/0", code_hi, valid_hi, cnt_hi);
    end
    tick();
    checks++;
    if (valid_hi !== 1'b0 || code_hi !== 3'd0) begin
      errors++;
      $display("FAIL bp_end valid=%b code=%0d expected 0/0", valid_hi, code_hi);
    end
    tick();
  endtask

  task automatic test_merge();
    out_ready = 1'b0;
    D = 8'h18;
    tick();
    D = 8'h00;
    tick();
    checks++;
    if (code_hi !== 3'd4 || valid_hi !== 1'b1 || cnt_hi !== 4'd1) begin
      errors++;
      $display("FAIL merge_setup code=%0d valid=%b cnt=%0d expected 4/1/1", code_hi, valid_hi, cnt_hi);
    end
    D = 8'h08;
    tick();
    D = 8'h00;
    checks++;
    if (merged_hi !== 1'b1 || cnt_hi !== 4'd1) begin
      errors++;
      $display("FAIL merge_pulse merged=%b cnt=%0d expected 1/1", merged_hi, cnt_hi);
    end
    tick();
    checks++;
    if (merged_hi !== 1'b0 || code_hi !== 3'd4 || valid_hi !== 1'b1) begin
      errors++;
      $display("FAIL merge_after merged=%b code=%0d valid=%b expected 0/4/1", merged_hi, code_hi, valid_hi);
    end
    out_ready = 1'b1;
    D = 8'h08;
    tick();
    D = 8'h00;
    checks++;
    if (merged_hi !== 1'b0 || code_hi !== 3'd3 || valid_hi !== 1'b1 || cnt_hi !== 4'd1) begin
      errors++;
      $display("FAIL set_clear merged=%b code=%0d valid=%b cnt=%0d expected 0/3/1/1", merged_hi, code_hi, valid_hi, cnt_hi);
    end
    tick();
    checks++;
    if (code_hi !== 3'd3 || valid_hi !== 1'b1 || cnt_hi !== 4'd0) begin
      errors++;
      $display("FAIL reissue code=%0d valid=%b cnt=%0d expected 3/1/0", code_hi, valid_hi, cnt_hi);
    end
    tick();
    checks++;
    if (valid_hi !== 1'b0) begin
      errors++;
      $display("FAIL merge_end valid=%b expected 0", valid_hi);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    D = 8'h01;
    tick();
    checks++;
    if (valid_hi !== 1'b0 || cnt_hi !== 4'd1) begin
      errors++;
      $display("FAIL stream_first valid=%b cnt=%0d expected 0/1", valid_hi, cnt_hi);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (valid_hi !== 1'b1 || code_hi !== 3'd0 || merged_hi !== 1'b0 || cnt_hi !== 4'd1) begin
        errors++;
        $display("FAIL stream cycle %0d valid=%b code=%0d merged=%b cnt=%0d expected 1/0/0/1", n, valid_hi, code_hi, merged_hi, cnt_hi);
      end
    end
    D = 8'h00;
    tick();
    checks++;
    if (valid_hi !== 1'b1 || cnt_hi !== 4'd0) begin
      errors++;
      $display("FAIL stream_last valid=%b cnt=%0d expected 1/0", valid_hi, cnt_hi);
    end
    tick();
    checks++;
    if (valid_hi !== 1'b0) begin
      errors++;
      $display("FAIL stream_end valid=%b expected 0", valid_hi);
    end
  endtask

  initial begin
    rst = 1'b1;
    D = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_priority_drain();
    test_backpressure();
    test_merge();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
